// File: rtl/phil_fork_arbiter_if.sv
// Request/release and grant bundle between the philosopher controllers
// and the fork arbiter. The master drives strobes; the slave (arbiter)
// drives grants, fork occupancy, starvation flags and the meal count.
interface phil_fork_arbiter_if #(
    parameter int N_PHIL = 5,
    parameter int MEAL_W = 16
);
    logic [N_PHIL-1:0] req;
    logic [N_PHIL-1:0] rel;
    logic [N_PHIL-1:0] grant;
    logic [N_PHIL-1:0] fork_busy;
    logic [N_PHIL-1:0] starve;
    logic [MEAL_W-1:0] meals;

    modport master (
        output req, rel,
        input  grant, fork_busy, starve, meals
    );

    modport slave (
        input  req, rel,
        output grant, fork_busy, starve, meals
    );
endinterface

// File: rtl/phil_fork_arbiter.sv
// Dining-philosophers fork arbiter. Philosopher i eats with forks i and
// i+1 (mod N), both granted atomically. Grants follow a round-robin scan
// from rr_ptr, with starving philosophers scanned first and their
// neighbours held off until the starving one gets to eat.
module phil_fork_arbiter #(
    parameter int N_PHIL     = 5,
    parameter int WAIT_W     = 4,
    parameter int STARVE_LIM = 8,
    parameter int MEAL_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    phil_fork_arbiter_if.slave bus
);
    localparam int PTR_W = (N_PHIL > 1) ? $clog2(N_PHIL) : 1;

    logic [N_PHIL-1:0] grant_r;
    logic [N_PHIL-1:0] fork_busy_r;
    logic [N_PHIL-1:0] starve_r;
    logic [MEAL_W-1:0] meals_r;
    logic [WAIT_W-1:0] wait_r [N_PHIL];
    logic [PTR_W-1:0]  rr_ptr_r;

    logic [N_PHIL-1:0] held_s;
    logic [N_PHIL-1:0] fork_held_s;
    logic [N_PHIL-1:0] cand_s;
    logic [N_PHIL-1:0] excl_s;
    logic [N_PHIL-1:0] claim_s;
    logic [N_PHIL-1:0] new_grant_s;
    logic [N_PHIL-1:0] grant_nxt_s;
    logic [N_PHIL-1:0] fork_busy_nxt_s;
    logic [N_PHIL-1:0] starve_nxt_s;
    logic [MEAL_W-1:0] meals_nxt_s;
    logic [WAIT_W-1:0] wait_nxt_s [N_PHIL];
    logic [PTR_W-1:0]  rr_ptr_nxt_s;
    logic              any_s;
    logic              ok_s;
    int                last_s;
    int                idx_s;

    // Ring successor index.
    function automatic int nxt(input int i);
        return (i == N_PHIL - 1) ? 0 : i + 1;
    endfunction

    // Ring predecessor index.
    function automatic int prv(input int i);
        return (i == 0) ? N_PHIL - 1 : i - 1;
    endfunction

    assign bus.grant     = grant_r;
    assign bus.fork_busy = fork_busy_r;
    assign bus.starve    = starve_r;
    assign bus.meals     = meals_r;

    // Fork availability (a releasing holder frees its forks this cycle),
    // grant candidates and neighbours locked out by starving philosophers.
    always_comb begin
        held_s      = grant_r & ~bus.rel;
        cand_s      = bus.req & ~grant_r & ~bus.rel;
        fork_held_s = '0;
        excl_s      = '0;
        for (int f = 0; f < N_PHIL; f++) begin
            fork_held_s[f] = held_s[f] | held_s[prv(f)];
        end
        // A starving neighbour with a lower index is not locked out, so
        // of two adjacent starving philosophers the lower index wins.
        for (int j = 0; j < N_PHIL; j++) begin
            excl_s[prv(j)] = excl_s[prv(j)] |
                (starve_r[j] & ~(starve_r[prv(j)] & (prv(j) < j)));
            excl_s[nxt(j)] = excl_s[nxt(j)] |
                (starve_r[j] & ~(starve_r[nxt(j)] & (nxt(j) < j)));
        end
    end

    // Grant scan: starving philosophers in index order, then everyone
    // else in round-robin order; forks taken earlier in the scan are claimed.
    always_comb begin
        claim_s     = '0;
        new_grant_s = '0;
        any_s       = 1'b0;
        ok_s        = 1'b0;
        last_s      = 0;
        idx_s       = 0;
        for (int i = 0; i < N_PHIL; i++) begin
            ok_s = starve_r[i] & cand_s[i] & ~excl_s[i] &
                   ~fork_held_s[i] & ~fork_held_s[nxt(i)] &
                   ~claim_s[i] & ~claim_s[nxt(i)];
            new_grant_s[i]      = new_grant_s[i] | ok_s;
            claim_s[i]          = claim_s[i] | ok_s;
            claim_s[nxt(i)]     = claim_s[nxt(i)] | ok_s;
            last_s              = ok_s ? i : last_s;
            any_s               = any_s | ok_s;
        end
        for (int i = 0; i < N_PHIL; i++) begin
            idx_s = int'(rr_ptr_r) + i;
            idx_s = (idx_s >= N_PHIL) ? idx_s - N_PHIL : idx_s;
            ok_s  = ~starve_r[idx_s] & cand_s[idx_s] & ~excl_s[idx_s] &
                    ~fork_held_s[idx_s] & ~fork_held_s[nxt(idx_s)] &
                    ~claim_s[idx_s] & ~claim_s[nxt(idx_s)];
            new_grant_s[idx_s]  = new_grant_s[idx_s] | ok_s;
            claim_s[idx_s]      = claim_s[idx_s] | ok_s;
            claim_s[nxt(idx_s)] = claim_s[nxt(idx_s)] | ok_s;
            last_s              = ok_s ? idx_s : last_s;
            any_s               = any_s | ok_s;
        end
        rr_ptr_nxt_s = any_s ? PTR_W'(nxt(last_s)) : rr_ptr_r;
    end

    // Next grants, fork occupancy, meal count and wait/starve tracking.
    always_comb begin
        grant_nxt_s     = (grant_r & ~bus.rel) | new_grant_s;
        fork_busy_nxt_s = '0;
        meals_nxt_s     = meals_r;
        starve_nxt_s    = starve_r;
        for (int f = 0; f < N_PHIL; f++) begin
            fork_busy_nxt_s[f] = grant_nxt_s[f] | grant_nxt_s[prv(f)];
        end
        for (int i = 0; i < N_PHIL; i++) begin
            meals_nxt_s = meals_nxt_s + {{(MEAL_W-1){1'b0}},
                (grant_r[i] & bus.rel[i] & ~(&meals_nxt_s))};
        end
        for (int i = 0; i < N_PHIL; i++) begin
            wait_nxt_s[i] = wait_r[i];
            if (!bus.req[i] || new_grant_s[i]) begin
                wait_nxt_s[i]   = '0;
                starve_nxt_s[i] = 1'b0;
            end else if (cand_s[i]) begin
                wait_nxt_s[i]   = (&wait_r[i]) ? wait_r[i] : wait_r[i] + WAIT_W'(1);
                starve_nxt_s[i] = starve_r[i] | (wait_nxt_s[i] >= WAIT_W'(STARVE_LIM));
            end else begin
                wait_nxt_s[i]   = wait_r[i];
                starve_nxt_s[i] = starve_r[i];
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            grant_r     <= '0;
            fork_busy_r <= '0;
            starve_r    <= '0;
            meals_r     <= '0;
            rr_ptr_r    <= '0;
            for (int i = 0; i < N_PHIL; i++) begin
                wait_r[i] <= '0;
            end
        end else begin
            grant_r     <= grant_nxt_s;
            fork_busy_r <= fork_busy_nxt_s;
            starve_r    <= starve_nxt_s;
            meals_r     <= meals_nxt_s;
            rr_ptr_r    <= rr_ptr_nxt_s;
            for (int i = 0; i < N_PHIL; i++) begin
                wait_r[i] <= wait_nxt_s[i];
            end
        end
    end
endmodule

// File: tb/tb_phil_fork_arbiter.sv
// Directed bench for phil_fork_arbiter (N=5, STARVE_LIM=4, MEAL_W=2)
// followed by a random request/release soak checking the no-adjacent-grant
// invariant and fork occupancy.
module tb_phil_fork_arbiter;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    phil_fork_arbiter_if #(.N_PHIL(5), .MEAL_W(2)) bus ();

    phil_fork_arbiter #(
        .N_PHIL(5), .WAIT_W(4), .STARVE_LIM(4), .MEAL_W(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [4:0] g;
        logic [4:0] fb;
        errors  = 0;
        checks  = 0;
        reset   = 1'b0;
        bus.req = 5'b00000;
        bus.rel = 5'b00000;

        // reset state
        step(); step();
        chk("rst_grant",  bus.grant,     32'h0);
        chk("rst_fbusy",  bus.fork_busy, 32'h0);
        chk("rst_starve", bus.starve,    32'h0);
        chk("rst_meals",  bus.meals,     32'h0);
        chk("rst_rrptr",  dut.rr_ptr_r,  32'h0);

        // all hungry from the first cycle
        reset   = 1'b1;
        bus.req = 5'b11111;
        step();
        chk("all_grant", bus.grant,     32'h05);
        chk("all_fbusy", bus.fork_busy, 32'h0F);
        chk("all_rrptr", dut.rr_ptr_r,  32'h3);

        // release 0: 4 takes over forks 4/0 without idle cycle, 0 not regranted
        bus.rel = 5'b00001;
        step();
        bus.rel = 5'b00000;
        chk("rel0_grant", bus.grant,     32'h14);
        chk("rel0_meals", bus.meals,     32'h1);
        chk("rel0_fbusy", bus.fork_busy, 32'h1D);

        // stray release and withdrawal of a hungry request
        reset   = 1'b0;
        bus.req = 5'b00000;
        step();
        reset   = 1'b1;
        bus.req = 5'b00111;
        step();
        chk("wd_grant0", bus.grant,     32'h05);
        chk("wd_wait1a", dut.wait_r[1], 32'h1);
        bus.req = 5'b00101;
        bus.rel = 5'b01000;
        step();
        bus.rel = 5'b00000;
        chk("wd_grant1", bus.grant,     32'h05);
        chk("wd_meals",  bus.meals,     32'h0);
        chk("wd_wait1b", dut.wait_r[1], 32'h0);
        chk("wd_starve", bus.starve,    32'h0);

        // starvation of philosopher 1 between eaters 0 and 2
        bus.req = 5'b00111;
        step(); step(); step();
        chk("stv_below", bus.starve, 32'h0);
        step();
        chk("stv_set", bus.starve, 32'h02);
        bus.rel = 5'b00001;
        step();
        bus.rel = 5'b00000;
        chk("stv_rel0_grant", bus.grant,     32'h04);
        chk("stv_rel0_fbusy", bus.fork_busy, 32'h0C);
        chk("stv_rel0_meals", bus.meals,     32'h1);
        step();
        chk("stv_excl_grant",  bus.grant,  32'h04);
        chk("stv_excl_starve", bus.starve, 32'h02);
        bus.rel = 5'b00100;
        step();
        bus.rel = 5'b00000;
        chk("stv_win_grant",  bus.grant,  32'h02);
        chk("stv_win_starve", bus.starve, 32'h0);
        chk("stv_win_meals",  bus.meals,  32'h2);

        // reset mid-meal with grant 01010
        bus.req = 5'b01010;
        step();
        chk("mid_grant", bus.grant,     32'h0A);
        chk("mid_fbusy", bus.fork_busy, 32'h1E);
        reset = 1'b0;
        step();
        chk("mid_rst_grant",  bus.grant,     32'h0);
        chk("mid_rst_fbusy",  bus.fork_busy, 32'h0);
        chk("mid_rst_starve", bus.starve,    32'h0);
        chk("mid_rst_meals",  bus.meals,     32'h0);

        // meal counter saturation at 2'b11
        reset   = 1'b1;
        bus.req = 5'b00001;
        step();
        chk("sat_grant0", bus.grant, 32'h01);
        for (int k = 1; k <= 5; k++) begin
            bus.rel = 5'b00001;
            step();
            bus.rel = 5'b00000;
            chk("sat_meals", bus.meals, (k < 3) ? k : 3);
            chk("sat_drop",  bus.grant, 32'h0);
            step();
            chk("sat_regrant", bus.grant, 32'h01);
        end

        // random soak: no adjacent grants, fork occupancy follows grants
        for (int c = 0; c < 10000; c++) begin
            bus.req = 5'($urandom_range(0, 31));
            bus.rel = 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31));
            step();
            g = bus.grant;
            for (int f = 0; f < 5; f++) begin
                fb[f] = g[f] | g[(f + 4) % 5];
            end
            chk("soak_adjacent", g & {g[0], g[4:1]}, 32'h0);
            chk("soak_fbusy", bus.fork_busy, fb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/phil_fork_arbiter.md
Name: phil_fork_arbiter

Overview:
- Synchronous arbiter for the dining-philosophers resource set: N philosophers share N forks arranged in a ring.
- Philosopher i needs fork i and fork (i+1) mod N, and is granted both atomically, so hold-and-wait deadlock cannot occur.
- Sits beside the synchronous Mealy MSFSM controller: philosopher request/release strobes come in, eat grants go back out.
- Provides round-robin fairness plus a starvation override.

Parameters:
N_PHIL, 5, number of philosophers and forks (legal range 3..16)
WAIT_W, 4, width of each per-philosopher wait counter
STARVE_LIM, 8, wait-cycle count at which a philosopher becomes starving (1..2^WAIT_W-1)
MEAL_W, 16, width of the total-meals counter

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
req  input  N_PHIL  level; bit i high = philosopher i hungry or eating
rel  input  N_PHIL  one-cycle pulse; bit i = philosopher i finished eating
grant  output  N_PHIL  level; bit i high = philosopher i holds both forks
fork_busy  output  N_PHIL  bit f high = fork f currently held
starve  output  N_PHIL  bit i high = philosopher i is starving
meals  output  MEAL_W  saturating count of completed meals

Behaviour:
- Reset (reset==0 at a clk edge):
  - grant, fork_busy, starve, meals, all wait counters and rr_ptr go to 0.
  - Applies mid-meal: all forks are freed immediately and no release is counted.
- Per-philosopher state, all registered:
  - THINK (req=0, grant=0).
  - HUNGRY (req=1, grant=0).
  - EAT (grant=1).
- Fork availability in cycle k:
  - A fork is free if it is not held, or if its holder has rel asserted in cycle k.
  - Handover therefore costs no idle cycle.
  - fork_busy[f] equals the OR of grant over the two philosophers adjacent to fork f.
- Grant decision in cycle k (takes effect at edge k+1):
  - Candidates are philosophers with req=1, grant=0 and rel=0. A philosopher releasing in cycle k cannot be regranted in cycle k.
  - Scan order is rr_ptr, rr_ptr+1, ... mod N.
  - Grant a candidate if both of its forks are free and neither is claimed by an earlier grant in the same scan.
  - Multiple non-adjacent grants per cycle are allowed.
- Starvation override:
  - If any starve[j]=1, philosophers j-1 and j+1 (mod N) are excluded from new grants until grant[j] rises.
  - Starving philosophers are scanned first, in index order.
  - Two adjacent starving philosophers: the lower index wins.
- rr_ptr update:
  - If at least one grant issued, rr_ptr becomes (highest-scan-order granted index + 1) mod N.
  - Otherwise rr_ptr is unchanged.
- Release:
  - rel[i] with grant[i]=1 clears grant[i] at the next edge and increments meals.
  - meals saturates at all-ones and never wraps.
  - rel[i] with grant[i]=0 is ignored.
  - req[i] falling while eating is ignored; only rel ends a meal.
- Request withdrawal: req[i] falling while HUNGRY returns i to THINK with no grant and clears wait[i] and starve[i].
- Wait counters:
  - wait[i] increments each cycle philosopher i is a candidate but is not granted, saturating at all-ones.
  - wait[i] clears on grant or when req[i]=0.
  - starve[i] sets when wait[i] reaches STARVE_LIM; it clears when grant[i] rises.
- Latency:
  - req rising at cycle k with forks free gives grant at k+1.
  - rel at cycle k gives grant drop, plus any neighbour grant, at k+1.
- Invariant: grant[i] & grant[(i+1) mod N] is never 1 in the same cycle.

Test Plan:
- Reset, then N=5 with req=5'b11111 from the first cycle -> one cycle later grant=5'b00101, fork_busy=5'b01111, rr_ptr=3.
- From that state, pulse rel[0] -> next cycle grant=5'b10100 and meals=1. Philosopher 0 is not regranted in the release cycle; philosopher 4 takes forks 4 and 0 with no idle cycle.
- STARVE_LIM=4; philosophers 0 and 2 eat continuously and philosopher 1 is held hungry -> starve[1]=1 after 4 wait cycles. Philosophers 0 and 2 are then not regranted after release, and grant[1]=1 occurs within one cycle of both forks 1 and 2 becoming free.
- Assert reset low while grant=5'b01010 -> next edge grant=0, fork_busy=0, meals unchanged from 0 path (reset value 0), starve=0.
- rel[3] pulse while grant[3]=0, and req[1] dropped while hungry -> no state change except wait[1]=0; meals unchanged.
- Force meals to all-ones via MEAL_W=2 and 5 releases -> meals holds 2'b11. Random req/rel soak of 10k cycles -> the adjacent-grant invariant is never violated.
